// File: rtl/apb_mem_slave.sv
// apb_mem_slave: register-array memory responder on a valid/ready interface.
// Each transfer is latched, then held through WAIT_CYCLES wait states.
// After that, ready_o pulses for one cycle. Only one transfer is outstanding.
// Optional feature: define APB_MEM_ERR_EN to add the error_o out-of-range flag.
module apb_mem_slave #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  wr_rd_i,
    input  logic                  valid_i,
    output logic [WIDTH-1:0]      rdata_o,
`ifdef APB_MEM_ERR_EN
    output logic                  error_o,
`endif
    output logic                  ready_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  wr_q;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  go_resp_c;
    logic [ADDR_WIDTH-1:0] acc_addr_c;
    logic [WIDTH-1:0]      acc_wdata_c;
    logic                  acc_wr_c;
    logic                  acc_in_range_c;
    logic [IDX_W-1:0]      acc_idx_c;

    // Select the transfer that completes on this edge.
    // It comes from the latch, or directly from the inputs when there are no wait states.
    always_comb begin
        go_resp_c   = 1'b0;
        acc_addr_c  = addr_q;
        acc_wdata_c = wdata_q;
        acc_wr_c    = wr_q;
        case (state)
            IDLE: begin
                if (valid_i && ZERO_WAIT) begin
                    go_resp_c   = 1'b1;
                    acc_addr_c  = addr_i;
                    acc_wdata_c = wdata_i;
                    acc_wr_c    = wr_rd_i;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    go_resp_c = 1'b1;
                end
            end
            default: ;
        endcase
        acc_in_range_c = ({1'b0, acc_addr_c} < DEPTH_LIM);
        acc_idx_c      = IDX_W'(acc_addr_c);
    end

    // FSM, storage and registered outputs.
    // Memory commit and the read load both happen on the edge that enters RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ready_o <= 1'b0;
            rdata_o <= '0;
`ifdef APB_MEM_ERR_EN
            error_o <= 1'b0;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ready_o <= go_resp_c;
`ifdef APB_MEM_ERR_EN
            error_o <= go_resp_c && !acc_in_range_c;
`endif
            if (go_resp_c) begin
                if (acc_wr_c && acc_in_range_c) begin
                    mem[acc_idx_c] <= acc_wdata_c;
                end
                if (!acc_wr_c) begin
                    rdata_o <= acc_in_range_c ? mem[acc_idx_c] : '0;
                end
            end

            case (state)
                IDLE: begin
                    if (valid_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        wr_q    <= wr_rd_i;
                        cnt     <= CNT_INIT;
                        state   <= ZERO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: self-checking bench for apb_mem_slave.
// It drives three instances with different wait-state counts and depths.
// A plain array-based memory model supplies the expected values.
module tb_apb_mem_slave;

    localparam int NDUT = 3;
    localparam int WC [NDUT] = '{2, 0, 3};
    localparam int DP [NDUT] = '{16, 16, 8};

    logic        clk;
    logic        rst;
    logic [3:0]  addr  [NDUT];
    logic [15:0] wdata [NDUT];
    logic        wr_rd [NDUT];
    logic        valid [NDUT];
    logic [15:0] rdata [NDUT];
    logic        ready [NDUT];
    logic        err   [NDUT];

    int vectors;
    int miscompares;

    logic [15:0] mem_m [NDUT][16];
    logic [15:0] rd_m  [NDUT];

    bit          hw [4];
    logic [3:0]  ha [4];
    logic [15:0] hd [4];

    apb_mem_slave #(.WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .WAIT_CYCLES(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr[0]), .wdata_i(wdata[0]), .wr_rd_i(wr_rd[0]),
        .valid_i(valid[0]), .rdata_o(rdata[0]),
`ifdef APB_MEM_ERR_EN
        .error_o(err[0]),
`endif
        .ready_o(ready[0])
    );

    apb_mem_slave #(.WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .WAIT_CYCLES(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr[1]), .wdata_i(wdata[1]), .wr_rd_i(wr_rd[1]),
        .valid_i(valid[1]), .rdata_o(rdata[1]),
`ifdef APB_MEM_ERR_EN
        .error_o(err[1]),
`endif
        .ready_o(ready[1])
    );

    apb_mem_slave #(.WIDTH(16), .ADDR_WIDTH(4), .DEPTH(8), .WAIT_CYCLES(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr[2]), .wdata_i(wdata[2]), .wr_rd_i(wr_rd[2]),
        .valid_i(valid[2]), .rdata_o(rdata[2]),
`ifdef APB_MEM_ERR_EN
        .error_o(err[2]),
`endif
        .ready_o(ready[2])
    );

`ifndef APB_MEM_ERR_EN
    initial begin
        for (int i = 0; i < NDUT; i++) err[i] = 1'b0;
    end
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < NDUT; d++) begin
            rd_m[d] = 16'h0;
            for (int a = 0; a < 16; a++) mem_m[d][a] = 16'h0;
        end
    endtask

    // Reference behaviour: in-range writes update, reads return the word or 0.
    task automatic model_apply(input int d, input bit wr, input logic [3:0] a, input logic [15:0] wd);
        if (wr) begin
            if (int'(a) < DP[d]) mem_m[d][a] = wd;
        end else begin
            rd_m[d] = (int'(a) < DP[d]) ? mem_m[d][a] : 16'h0;
        end
    endtask

    task automatic chk_resp(input int d, input logic [3:0] a);
        chk($sformatf("rdata_d%0d", d), 32'(rdata[d]), 32'(rd_m[d]));
`ifdef APB_MEM_ERR_EN
        chk($sformatf("error_d%0d", d), 32'(err[d]), 32'(int'(a) >= DP[d]));
`endif
    endtask

    // Single transfer starting at a negedge with the DUT idle.
    task automatic xfer(input int d, input bit wr, input logic [3:0] a, input logic [15:0] wd,
                        input bit disturb);
        int n;
        addr[d] = a; wdata[d] = wd; wr_rd[d] = wr; valid[d] = 1'b1;
        @(posedge clk);
        #1;
        if (disturb) begin
            valid[d] = 1'b0; addr[d] = 4'd7; wdata[d] = ~wd; wr_rd[d] = ~wr;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[d] && n < 40);
        chk($sformatf("latency_d%0d", d), 32'(n), 32'(WC[d] + 1));
        valid[d] = 1'b0;
        model_apply(d, wr, a, wd);
        chk_resp(d, a);
        @(negedge clk);
        chk($sformatf("pulse_end_d%0d", d), 32'(ready[d]), 32'd0);
        chk($sformatf("err_idle_d%0d", d), 32'(err[d]), 32'd0);
    endtask

    // valid held high across n transfers taken from hw/ha/hd.
    task automatic held_seq(input int d, input int n);
        int cyc, last, pulses;
        addr[d] = ha[0]; wdata[d] = hd[0]; wr_rd[d] = hw[0]; valid[d] = 1'b1;
        cyc = 0; last = 0; pulses = 0;
        while (pulses < n && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (ready[d]) begin
                if (pulses == 0) chk($sformatf("first_lat_d%0d", d), 32'(cyc), 32'(WC[d] + 1));
                else             chk($sformatf("spacing_d%0d", d), 32'(cyc - last), 32'(WC[d] + 2));
                model_apply(d, hw[pulses], ha[pulses], hd[pulses]);
                chk_resp(d, ha[pulses]);
                last = cyc;
                pulses++;
                if (pulses < n) begin
                    addr[d] = ha[pulses]; wdata[d] = hd[pulses]; wr_rd[d] = hw[pulses];
                end else begin
                    valid[d] = 1'b0;
                end
            end
        end
        chk($sformatf("pulse_count_d%0d", d), 32'(pulses), 32'(n));
        repeat (WC[d] + 3) begin
            @(negedge clk);
            if (ready[d]) pulses++;
        end
        chk($sformatf("no_extra_d%0d", d), 32'(pulses), 32'(n));
    endtask

    task automatic chk_all_reset(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_ready_d%0d", tag, d), 32'(ready[d]), 32'd0);
            chk($sformatf("%s_rdata_d%0d", tag, d), 32'(rdata[d]), 32'd0);
            chk($sformatf("%s_err_d%0d", tag, d), 32'(err[d]), 32'd0);
        end
    endtask

    initial begin
        int d, pulses;
        bit wr;
        logic [3:0] a;
        logic [15:0] wd;

        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            addr[i] = 4'd0; wdata[i] = 16'h0; wr_rd[i] = 1'b0; valid[i] = 1'b0;
        end
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        // Write then read back with two wait states.
        xfer(0, 1'b1, 4'd3, 16'hA5A5, 1'b0);
        xfer(0, 1'b0, 4'd3, 16'h0000, 1'b0);

        // No wait states: back-to-back with valid held, including the top address.
        hw = '{1'b1, 1'b1, 1'b0, 1'b0};
        ha = '{4'd0, 4'd15, 4'd0, 4'd15};
        hd = '{16'h1234, 16'h1234, 16'h0, 16'h0};
        held_seq(1, 4);

        // Reset in the middle of a write abandons it and clears memory.
        xfer(0, 1'b1, 4'd5, 16'h5555, 1'b0);
        xfer(0, 1'b0, 4'd5, 16'h0, 1'b0);
        addr[0] = 4'd5; wdata[0] = 16'h7777; wr_rd[0] = 1'b1; valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_reset("midreset");
        rst = 1'b1;
        model_clear();
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready[0]) pulses++;
        end
        chk("abandoned_pulse", 32'(pulses), 32'd0);
        xfer(0, 1'b0, 4'd5, 16'h0, 1'b0);

        // Inputs change during the wait states; the latched read still completes.
        xfer(0, 1'b1, 4'd2, 16'hBEEF, 1'b0);
        xfer(0, 1'b1, 4'd7, 16'h0707, 1'b0);
        xfer(0, 1'b0, 4'd2, 16'h0, 1'b1);

        // Depth 8: out-of-range write is discarded, and an out-of-range read returns 0.
        xfer(2, 1'b1, 4'd7, 16'h7E7E, 1'b0);
        xfer(2, 1'b1, 4'd9, 16'hFFFF, 1'b0);
        xfer(2, 1'b0, 4'd7, 16'h0, 1'b0);
        xfer(2, 1'b0, 4'd9, 16'h0, 1'b0);
        xfer(2, 1'b1, 4'd8, 16'hFFFF, 1'b0);
        xfer(2, 1'b0, 4'd1, 16'h0, 1'b0);

        // Three held reads spaced WAIT_CYCLES+2 apart.
        xfer(0, 1'b1, 4'd1, 16'h1111, 1'b0);
        xfer(0, 1'b1, 4'd3, 16'h3333, 1'b0);
        hw = '{1'b0, 1'b0, 1'b0, 1'b0};
        ha = '{4'd1, 4'd2, 4'd3, 4'd0};
        hd = '{16'h0, 16'h0, 16'h0, 16'h0};
        held_seq(0, 3);

        // Randomised transfers on all instances.
        for (int k = 0; k < 60; k++) begin
            d  = int'($urandom_range(0, NDUT - 1));
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            wd = 16'($urandom);
            xfer(d, wr, a, wd, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
